bist_pattern_gen: RTL and testbench

LFSR-based test-pattern source that sits directly upstream of the gate-level sequential benchmark netlist. It drives the netlist's primary inputs (G0..G3) in BIST mode. Software or the bench loads a seed and a pattern count, pulses start, and the block emits a pseudo-random pattern stream under a valid/ready handshake. The block signals done after the last pattern is accepted.

---
 rtl/bist_pattern_gen.sv | 128 ++++++++++++
 tb/tb_bist_pattern_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: LFSR test-pattern source driving the benchmark netlist
// primary inputs (bit i -> Gi) under a valid/ready handshake.
// Optional build macro: BIST_ZERO_PATTERN_EN inserts one all-zero pattern
// each time the LFSR returns to its start seed (exhaustive 2^WIDTH cycle).
module bist_pattern_gen #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(4'b1001),
    parameter int              CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic             pat_ready,
    output logic             pat_valid,
    output logic [WIDTH-1:0] pat_data,
    output logic [CNT_W-1:0] pat_index,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_eff;
    logic [CNT_W-1:0] count;
    logic             last;

`ifdef BIST_ZERO_PATTERN_EN
    logic [WIDTH-1:0] start_lfsr;
    logic             zero_phase;
`endif

    // Next LFSR value, lockup-safe seed and final-pattern detect
    always_comb begin
        lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
        seed_eff  = (seed == '0) ? WIDTH'(1) : seed;
        last      = (pat_index == count - CNT_W'(1));
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= '0;
            count      <= '0;
            pat_index  <= '0;
            pat_valid  <= 1'b0;
            pat_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef BIST_ZERO_PATTERN_EN
            start_lfsr <= '0;
            zero_phase <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr      <= seed_eff;
                        pat_data  <= seed_eff;
                        count     <= num_patterns;
                        pat_index <= '0;
                        busy      <= 1'b1;
`ifdef BIST_ZERO_PATTERN_EN
                        start_lfsr <= seed_eff;
                        zero_phase <= 1'b0;
`endif
                        if (num_patterns == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            pat_valid <= 1'b0;
                        end else begin
                            state     <= RUN;
                            pat_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pat_valid && pat_ready) begin
                        pat_index <= pat_index + CNT_W'(1);
`ifdef BIST_ZERO_PATTERN_EN
                        // The LFSR already sits on the seed while the zero is
                        // shown, so resuming just republishes the held state.
                        if (zero_phase) begin
                            pat_data   <= lfsr;
                            zero_phase <= 1'b0;
                        end else if (lfsr_next == start_lfsr) begin
                            lfsr       <= lfsr_next;
                            pat_data   <= '0;
                            zero_phase <= 1'b1;
                        end else begin
                            lfsr     <= lfsr_next;
                            pat_data <= lfsr_next;
                        end
`else
                        lfsr     <= lfsr_next;
                        pat_data <= lfsr_next;
`endif
                        if (last) begin
                            state     <= DONE;
                            pat_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    pat_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_pattern_gen.sv
// tb_bist_pattern_gen: randomized and directed bench for bist_pattern_gen
// with a sequence-level reference model. Honours BIST_ZERO_PATTERN_EN.
module tb_bist_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] seed;
    logic [7:0] num_patterns;
    logic       pat_ready;
    logic       pat_valid;
    logic [3:0] pat_data;
    logic [7:0] pat_index;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // reference model state: phase 0=idle 1=emitting 2=done-pulse
    int         m_phase = 0;
    int         m_k     = 0;
    int         m_n     = 0;
    logic [3:0] m_seed  = 4'd1;

    logic [3:0] cap[$];

    bist_pattern_gen #(.WIDTH(4), .TAPS(4'b1001), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .seed         (seed),
        .num_patterns (num_patterns),
        .pat_ready    (pat_ready),
        .pat_valid    (pat_valid),
        .pat_data     (pat_data),
        .pat_index    (pat_index),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // k-th pattern of a run: one full LFSR period from the seed, plus the
    // optional zero, repeated indefinitely
    function automatic logic [3:0] pat(input logic [3:0] s0, input int k);
        logic [3:0] seq[$];
        logic [3:0] s;
        s = s0;
        for (int i = 0; i < 16; i++) begin
            seq.push_back(s);
            s = {s[2:0], ^(s & 4'b1001)};
            if (s == s0) break;
        end
`ifdef BIST_ZERO_PATTERN_EN
        seq.push_back(4'b0000);
`endif
        return seq[k % seq.size()];
    endfunction

    // Reference model of run progress, advanced on each rising edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_k     = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_seed  = (seed == 4'd0) ? 4'd1 : seed;
                    m_n     = int'(num_patterns);
                    m_k     = 0;
                    m_phase = (num_patterns == 8'd0) ? 2 : 1;
                end
                1: if (pat_ready) begin
                    if (m_k == m_n - 1) m_phase = 2;
                    m_k++;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", pat_valid, 0);
            chk("rst_data", pat_data, 0);
            chk("rst_index", pat_index, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end else begin
            chk("valid", pat_valid, (m_phase == 1) ? 1 : 0);
            chk("busy", busy, (m_phase != 0) ? 1 : 0);
            chk("done", done, (m_phase == 2) ? 1 : 0);
            if (m_phase == 1) begin
                chk("data", pat_data, pat(m_seed, m_k));
                chk("index", pat_index, m_k);
                if (pat_valid && pat_ready) cap.push_back(pat_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input logic [3:0] sd, input int n, input int stall_idx,
                       input int stall_len, input bit rnd);
        int cnt;
        int guard;
        cap.delete();
        seed         = sd;
        num_patterns = 8'(n);
        start        = 1'b1;
        pat_ready    = 1'b1;
        tick();
        start = 1'b0;
        seed  = 4'($urandom);
        cnt   = 0;
        guard = 0;
        while (m_phase != 0 && guard < 2000) begin
            if (rnd) begin
                pat_ready = (($urandom % 4) != 0);
                start     = (($urandom % 8) == 0);
            end else if (m_phase == 1 && m_k == stall_idx && cnt < stall_len) begin
                pat_ready = 1'b0;
                cnt++;
            end else begin
                pat_ready = 1'b1;
            end
            tick();
            guard++;
        end
        start     = 1'b0;
        pat_ready = 1'b1;
        if (m_phase != 0) begin
            checks++;
            errors++;
            $display("FAIL run_timeout actual=phase%0d required=idle", m_phase);
        end
    endtask

    initial begin
        int guard;
        rst_n        = 1'b0;
        start        = 1'b0;
        seed         = 4'd0;
        num_patterns = 8'd0;
        pat_ready    = 1'b1;

        // pin the reference model itself
        chk("model_p0", pat(4'd1, 0), 4'b0001);
        chk("model_p1", pat(4'd1, 1), 4'b0011);
        chk("model_p2", pat(4'd1, 2), 4'b0111);
`ifdef BIST_ZERO_PATTERN_EN
        chk("model_p15", pat(4'd1, 15), 4'b0000);
        chk("model_p16", pat(4'd1, 16), 4'b0001);
`else
        chk("model_p15", pat(4'd1, 15), 4'b0001);
        chk("model_p16", pat(4'd1, 16), 4'b0011);
`endif

        tick();
        tick();
        chk("reset_valid", pat_valid, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // basic three-pattern run
        run(4'b0001, 3, -1, 0, 1'b0);
        chk("t1_count", cap.size(), 3);
        if (cap.size() == 3) begin
            chk("t1_p0", cap[0], 4'b0001);
            chk("t1_p1", cap[1], 4'b0011);
            chk("t1_p2", cap[2], 4'b0111);
        end

        // stall four cycles on index 1
        run(4'b0001, 3, 1, 4, 1'b0);
        chk("t2_count", cap.size(), 3);
        if (cap.size() == 3) begin
            chk("t2_p1", cap[1], 4'b0011);
            chk("t2_p2", cap[2], 4'b0111);
        end

        // zero-length run: done only
        run(4'b0101, 0, -1, 0, 1'b0);
        chk("t3_count", cap.size(), 0);

        // zero seed replaced by 1
        run(4'b0000, 2, -1, 0, 1'b0);
        chk("t4_count", cap.size(), 2);
        if (cap.size() == 2) begin
            chk("t4_p0", cap[0], 4'b0001);
            chk("t4_p1", cap[1], 4'b0011);
        end

        // run past the LFSR period
        run(4'b0001, 17, -1, 0, 1'b0);
        chk("t5_count", cap.size(), 17);
        if (cap.size() == 17) begin
`ifdef BIST_ZERO_PATTERN_EN
            chk("t5_p15", cap[15], 4'b0000);
            chk("t5_p16", cap[16], 4'b0001);
`else
            chk("t5_p15", cap[15], 4'b0001);
            chk("t5_p16", cap[16], 4'b0011);
`endif
        end

        // asynchronous reset mid-run at index 5
        seed         = 4'b0001;
        num_patterns = 8'd20;
        start        = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (m_k != 5 && guard < 50) begin
            tick();
            guard++;
        end
        chk("t6_reached_idx5", pat_index, 5);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", pat_valid, 0);
        chk("t6_async_data", pat_data, 0);
        chk("t6_async_index", pat_index, 0);
        chk("t6_async_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run(4'b1001, 4, -1, 0, 1'b0);
        chk("t6_count", cap.size(), 4);
        if (cap.size() == 4) begin
            chk("t6_p0", cap[0], 4'b1001);
            chk("t6_p1", cap[1], 4'b0010);
            chk("t6_p2", cap[2], 4'b0100);
            chk("t6_p3", cap[3], 4'b1000);
        end

        // randomized runs with random backpressure and stray starts
        for (int r = 0; r < 20; r++) begin
            run(4'($urandom), $urandom_range(0, 40), -1, 0, 1'b1);
            tick();
        end

        // maximum count
        run(4'($urandom), 255, -1, 0, 1'b1);
        chk("max_count", cap.size(), 255);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
